// File: rtl/binary_ops_pipe_stage_if.sv
// ----------------------------------------------------------------------------
// binary_ops_pipe_stage_if
//
// Purpose:
//   Bundles the upstream operand handshake, the downstream result handshake
//   and the status outputs of binary_ops_pipe_stage into one interface.
//
// Signals:
//   in_valid  : upstream presents a, b, op
//   in_ready  : stage accepts this cycle
//   a, b      : operands, WIDTH bits
//   op        : 0=AND, 1=OR, 2=XOR, 3=XNOR
//   out_valid : result y is valid
//   out_ready : downstream accepts y
//   y         : registered result, WIDTH bits
//   y_zero    : y == 0, registered with y
//   done_cnt  : count of completed output handshakes, CNT_WIDTH bits
//   y_parity  : ^y, registered with y (only with BINARY_OPS_PIPE_PARITY_EN)
//
// Modports:
//   master : the side that drives operands and out_ready (source/sink)
//   slave  : the pipeline stage itself
//
// Configuration macro: BINARY_OPS_PIPE_PARITY_EN adds y_parity.
// ----------------------------------------------------------------------------
interface binary_ops_pipe_stage_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [1:0]           op;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     y;
    logic                 y_zero;
    logic [CNT_WIDTH-1:0] done_cnt;
`ifdef BINARY_OPS_PIPE_PARITY_EN
    logic                 y_parity;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, y_zero, done_cnt, y_parity
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, y_zero, done_cnt, y_parity
    );
`else
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, y_zero, done_cnt
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, y_zero, done_cnt
    );
`endif
endinterface

// File: rtl/binary_ops_pipe_stage.sv
// ----------------------------------------------------------------------------
// binary_ops_pipe_stage
//
// Purpose:
//   Two-stage registered bitwise-operator pipeline. Stage S1 registers the
//   operands and op select; stage S2 registers the AND/OR/XOR/XNOR result
//   together with a zero flag. Both sides use valid/ready handshakes and the
//   stage sustains one transaction per cycle. A counter tracks completed
//   output handshakes and wraps at 2^CNT_WIDTH.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : binary_ops_pipe_stage_if.slave (operands in, result out, status)
//
// Parameters:
//   WIDTH     : operand/result width (>= 1)
//   CNT_WIDTH : completed-transaction counter width (>= 1)
//
// Configuration macro:
//   BINARY_OPS_PIPE_PARITY_EN : adds bus.y_parity = ^y, registered with y.
// ----------------------------------------------------------------------------
module binary_ops_pipe_stage #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst,
    binary_ops_pipe_stage_if.slave bus
);

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_XNOR = 2'd3
    } op_e;

    logic                 s1Valid_q, s1Valid_d;
    logic [WIDTH-1:0]     s1A_q, s1A_d;
    logic [WIDTH-1:0]     s1B_q, s1B_d;
    op_e                  s1Op_q, s1Op_d;
    logic                 s2Valid_q, s2Valid_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic                 yZero_q, yZero_d;
    logic [CNT_WIDTH-1:0] doneCnt_q, doneCnt_d;
`ifdef BINARY_OPS_PIPE_PARITY_EN
    logic                 yParity_q, yParity_d;
`endif

    logic             s1Ready;
    logic             inReady;
    logic             accept;
    logic             s1Move;
    logic             outFire;
    logic [WIDTH-1:0] opResult;

    // Ready chain: S2 can take new data when it is empty or draining this
    // cycle, and S1 can take new data when it is empty or moving into S2.
    // This lets a full pipeline drain, advance and refill on the same edge.
    always_comb begin
        s1Ready = !s2Valid_q || bus.out_ready;
        inReady = !s1Valid_q || s1Ready;
        accept  = bus.in_valid && inReady;
        s1Move  = s1Valid_q && s1Ready;
        outFire = s2Valid_q && bus.out_ready;
    end

    // The operator works only on the registered S1 operands, so there is
    // never a combinational path from a, b or op through to y.
    always_comb begin
        opResult = '0;
        case (s1Op_q)
            OP_AND:  opResult = s1A_q & s1B_q;
            OP_OR:   opResult = s1A_q | s1B_q;
            OP_XOR:  opResult = s1A_q ^ s1B_q;
            OP_XNOR: opResult = ~(s1A_q ^ s1B_q);
            default: opResult = '0;
        endcase
    end

    // Next-state logic. Clearing a valid flag before setting it lets a stage
    // be emptied and refilled in the same cycle without a bubble. Results and
    // flags only change on a transfer, so they hold under backpressure.
    always_comb begin
        s1Valid_d = s1Valid_q;
        s1A_d     = s1A_q;
        s1B_d     = s1B_q;
        s1Op_d    = s1Op_q;
        s2Valid_d = s2Valid_q;
        y_d       = y_q;
        yZero_d   = yZero_q;
        doneCnt_d = doneCnt_q;
`ifdef BINARY_OPS_PIPE_PARITY_EN
        yParity_d = yParity_q;
`endif

        if (s1Move) begin
            s1Valid_d = 1'b0;
        end
        if (accept) begin
            s1Valid_d = 1'b1;
            s1A_d     = bus.a;
            s1B_d     = bus.b;
            s1Op_d    = op_e'(bus.op);
        end

        if (outFire) begin
            s2Valid_d = 1'b0;
            doneCnt_d = doneCnt_q + CNT_WIDTH'(1);
        end
        if (s1Move) begin
            s2Valid_d = 1'b1;
            y_d       = opResult;
            yZero_d   = (opResult == '0);
`ifdef BINARY_OPS_PIPE_PARITY_EN
            yParity_d = ^opResult;
`endif
        end
    end

    // State registers. Reset drops any in-flight data outright; no output
    // handshake is generated for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Op_q    <= OP_AND;
            s2Valid_q <= 1'b0;
            y_q       <= '0;
            yZero_q   <= 1'b1;
            doneCnt_q <= '0;
`ifdef BINARY_OPS_PIPE_PARITY_EN
            yParity_q <= 1'b0;
`endif
        end else begin
            s1Valid_q <= s1Valid_d;
            s1A_q     <= s1A_d;
            s1B_q     <= s1B_d;
            s1Op_q    <= s1Op_d;
            s2Valid_q <= s2Valid_d;
            y_q       <= y_d;
            yZero_q   <= yZero_d;
            doneCnt_q <= doneCnt_d;
`ifdef BINARY_OPS_PIPE_PARITY_EN
            yParity_q <= yParity_d;
`endif
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = s2Valid_q;
    assign bus.y         = y_q;
    assign bus.y_zero    = yZero_q;
    assign bus.done_cnt  = doneCnt_q;
`ifdef BINARY_OPS_PIPE_PARITY_EN
    assign bus.y_parity  = yParity_q;
`endif

endmodule

// File: tb/tb_binary_ops_pipe_stage.sv
// ----------------------------------------------------------------------------
// tb_binary_ops_pipe_stage
//
// Directed testbench for binary_ops_pipe_stage. A default instance (8-bit
// counter) covers reset, operators, backpressure, back-to-back flow and
// mid-stream reset; a second instance with CNT_WIDTH=2 covers counter wrap.
// Inputs change and outputs are sampled around the falling clock edge.
// ----------------------------------------------------------------------------
module tb_binary_ops_pipe_stage;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    binary_ops_pipe_stage_if #(.WIDTH(8), .CNT_WIDTH(8)) busMain ();
    binary_ops_pipe_stage_if #(.WIDTH(8), .CNT_WIDTH(2)) busWrap ();

    binary_ops_pipe_stage #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busMain.slave)
    );

    binary_ops_pipe_stage #(.WIDTH(8), .CNT_WIDTH(2)) dutWrap (
        .clk (clk),
        .rst (rst),
        .bus (busWrap.slave)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock: through the rising edge to the next falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        busMain.in_valid = 1'b1;
        busMain.a        = 8'h5A;
        busMain.b        = 8'h3C;
        busMain.op       = 2'd2;
        busMain.out_ready = 1'b0;
        busWrap.in_valid = 1'b0;
        busWrap.a        = 8'h00;
        busWrap.b        = 8'h00;
        busWrap.op       = 2'd0;
        busWrap.out_ready = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        #1;
        total++;
        if (busMain.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_out_valid got=%b want=0", busMain.out_valid);
        end
        total++;
        if (busMain.y !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_y got=%h want=00", busMain.y);
        end
        total++;
        if (busMain.y_zero !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_y_zero got=%b want=1", busMain.y_zero);
        end
        total++;
        if (busMain.done_cnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_done_cnt got=%0d want=0", busMain.done_cnt);
        end
`ifdef BINARY_OPS_PIPE_PARITY_EN
        total++;
        if (busMain.y_parity !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_y_parity got=%b want=0", busMain.y_parity);
        end
`endif
        @(negedge clk);
        rst              = 1'b0;
        busMain.in_valid = 1'b0;
        busMain.out_ready = 1'b1;
        #1;
        total++;
        if (busMain.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready got=%b want=1", busMain.in_ready);
        end
    endtask

    task automatic test_all_ops();
        logic [7:0] expY [4];
        expY[0] = 8'h81;
        expY[1] = 8'hE7;
        expY[2] = 8'h66;
        expY[3] = 8'h99;
        busMain.a         = 8'hC3;
        busMain.b         = 8'hA5;
        busMain.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            busMain.in_valid = (i < 4);
            busMain.op       = (i < 4) ? 2'(i) : 2'd0;
            #1;
            if (i < 4) begin
                total++;
                if (busMain.in_ready !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL ops_in_ready cyc=%0d got=%b want=1", i, busMain.in_ready);
                end
            end
            if (i == 1 || i == 6) begin
                total++;
                if (busMain.out_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL ops_out_valid_idle cyc=%0d got=%b want=0", i, busMain.out_valid);
                end
            end
            if (i >= 2 && i <= 5) begin
                total++;
                if (busMain.out_valid !== 1'b1 || busMain.y !== expY[i-2] || busMain.y_zero !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL ops_result cyc=%0d got=v%b y=%h z=%b want=v1 y=%h z=0",
                             i, busMain.out_valid, busMain.y, busMain.y_zero, expY[i-2]);
                end
            end
            if (i == 6) begin
                total++;
                if (busMain.done_cnt !== 8'd4) begin
                    bad++;
                    $display("[TB] FAIL ops_done_cnt got=%0d want=4", busMain.done_cnt);
                end
            end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        logic       expReady [4];
        logic [7:0] bVals    [4];
        logic [7:0] drainY   [3];
        logic       drainZ   [3];
        expReady[0] = 1'b1; expReady[1] = 1'b1; expReady[2] = 1'b0; expReady[3] = 1'b0;
        bVals[0] = 8'h0F;   bVals[1] = 8'hF0;   bVals[2] = 8'hFF;   bVals[3] = 8'hFF;
        drainY[0] = 8'hF0;  drainY[1] = 8'h0F;  drainY[2] = 8'h00;
        drainZ[0] = 1'b0;   drainZ[1] = 1'b0;   drainZ[2] = 1'b1;
        busMain.op        = 2'd2;
        busMain.a         = 8'hFF;
        busMain.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            busMain.in_valid = 1'b1;
            busMain.b        = bVals[i];
            #1;
            total++;
            if (busMain.in_ready !== expReady[i]) begin
                bad++;
                $display("[TB] FAIL bp_in_ready cyc=%0d got=%b want=%b", i, busMain.in_ready, expReady[i]);
            end
            if (i >= 2) begin
                total++;
                if (busMain.out_valid !== 1'b1 || busMain.y !== 8'hF0 || busMain.y_zero !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL bp_hold cyc=%0d got=v%b y=%h z=%b want=v1 y=f0 z=0",
                             i, busMain.out_valid, busMain.y, busMain.y_zero);
                end
            end
            cycle();
        end
        // Release: the stalled b=FF is accepted on the first draining edge.
        busMain.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            busMain.in_valid = (i == 0);
            #1;
            if (i == 0) begin
                total++;
                if (busMain.in_ready !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL bp_release_ready got=%b want=1", busMain.in_ready);
                end
            end
            if (i < 3) begin
                total++;
                if (busMain.out_valid !== 1'b1 || busMain.y !== drainY[i] || busMain.y_zero !== drainZ[i]) begin
                    bad++;
                    $display("[TB] FAIL bp_drain idx=%0d got=v%b y=%h z=%b want=v1 y=%h z=%b",
                             i, busMain.out_valid, busMain.y, busMain.y_zero, drainY[i], drainZ[i]);
                end
            end else begin
                total++;
                if (busMain.out_valid !== 1'b0 || busMain.done_cnt !== 8'd7) begin
                    bad++;
                    $display("[TB] FAIL bp_end got=v%b cnt=%0d want=v0 cnt=7",
                             busMain.out_valid, busMain.done_cnt);
                end
            end
            cycle();
        end
    endtask

    task automatic test_back_to_back();
        busMain.op = 2'd0;
        busMain.a  = 8'hFF;
        for (int i = 0; i < 11; i++) begin
            busMain.out_ready = (i >= 2);
            busMain.in_valid  = (i < 8);
            busMain.b         = 8'(8'h10 + i);
            #1;
            if (i >= 2 && i < 8) begin
                total++;
                if (busMain.in_ready !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL b2b_in_ready cyc=%0d got=%b want=1", i, busMain.in_ready);
                end
            end
            if (i >= 2 && i < 10) begin
                total++;
                if (busMain.out_valid !== 1'b1 || busMain.y !== 8'(8'h10 + i - 2)) begin
                    bad++;
                    $display("[TB] FAIL b2b_out cyc=%0d got=v%b y=%h want=v1 y=%h",
                             i, busMain.out_valid, busMain.y, 8'(8'h10 + i - 2));
                end
            end
            if (i == 10) begin
                total++;
                if (busMain.out_valid !== 1'b0 || busMain.done_cnt !== 8'd15) begin
                    bad++;
                    $display("[TB] FAIL b2b_end got=v%b cnt=%0d want=v0 cnt=15",
                             busMain.out_valid, busMain.done_cnt);
                end
            end
            cycle();
        end
    endtask

    task automatic test_reset_midstream();
        busMain.op        = 2'd3;
        busMain.a         = 8'h00;
        busMain.b         = 8'h00;
        busMain.out_ready = 1'b0;
        busMain.in_valid  = 1'b1;
        cycle();
        cycle();
        #1;
        total++;
        if (busMain.out_valid !== 1'b1 || busMain.in_ready !== 1'b0 || busMain.y !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL mid_full got=v%b r=%b y=%h want=v1 r=0 y=ff",
                     busMain.out_valid, busMain.in_ready, busMain.y);
        end
        rst              = 1'b1;
        busMain.in_valid = 1'b0;
        cycle();
        #1;
        total++;
        if (busMain.out_valid !== 1'b0 || busMain.done_cnt !== 8'd0 ||
            busMain.y !== 8'h00 || busMain.y_zero !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_reset got=v%b cnt=%0d y=%h z=%b want=v0 cnt=0 y=00 z=1",
                     busMain.out_valid, busMain.done_cnt, busMain.y, busMain.y_zero);
        end
        rst               = 1'b0;
        busMain.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            #1;
            total++;
            if (busMain.out_valid !== 1'b0 || busMain.done_cnt !== 8'd0) begin
                bad++;
                $display("[TB] FAIL mid_stale cyc=%0d got=v%b cnt=%0d want=v0 cnt=0",
                         i, busMain.out_valid, busMain.done_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] expCnt [8];
        expCnt[0] = 2'd0; expCnt[1] = 2'd0; expCnt[2] = 2'd0; expCnt[3] = 2'd1;
        expCnt[4] = 2'd2; expCnt[5] = 2'd3; expCnt[6] = 2'd0; expCnt[7] = 2'd1;
        busWrap.out_ready = 1'b1;
        busWrap.a         = 8'h33;
        busWrap.b         = 8'h55;
        busWrap.op        = 2'd1;
        for (int i = 0; i < 8; i++) begin
            busWrap.in_valid = (i < 5);
            #1;
            total++;
            if (busWrap.done_cnt !== expCnt[i]) begin
                bad++;
                $display("[TB] FAIL wrap_cnt cyc=%0d got=%0d want=%0d", i, busWrap.done_cnt, expCnt[i]);
            end
            cycle();
        end
        busWrap.in_valid = 1'b0;
    endtask

`ifdef BINARY_OPS_PIPE_PARITY_EN
    task automatic test_parity();
        logic [7:0] aVals [2];
        logic [7:0] expY  [2];
        logic       expP  [2];
        aVals[0] = 8'h07; expY[0] = 8'h07; expP[0] = 1'b1;
        aVals[1] = 8'h03; expY[1] = 8'h03; expP[1] = 1'b0;
        busMain.b         = 8'h00;
        busMain.op        = 2'd1;
        busMain.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            busMain.in_valid = (i < 2);
            busMain.a        = (i < 2) ? aVals[i] : 8'h00;
            #1;
            if (i >= 2) begin
                total++;
                if (busMain.out_valid !== 1'b1 || busMain.y !== expY[i-2] || busMain.y_parity !== expP[i-2]) begin
                    bad++;
                    $display("[TB] FAIL parity idx=%0d got=v%b y=%h p=%b want=v1 y=%h p=%b",
                             i - 2, busMain.out_valid, busMain.y, busMain.y_parity, expY[i-2], expP[i-2]);
                end
            end
            cycle();
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_all_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_wrap();
`ifdef BINARY_OPS_PIPE_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/binary_ops_pipe_stage.md
Name: binary_ops_pipe_stage

Overview:
- Two-stage registered bitwise-operator pipeline with valid/ready handshake on both sides.
- Each accepted transaction carries operands a, b and an op select; the stage returns one of AND/OR/XOR/XNOR.
- It is the sequential counterpart of the combinational binary-operator benchmark and sits directly downstream of an operand source.
- Used as a sequential netlist benchmark: registers, enables, muxed datapath, handshake logic and a counter.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 1).
- CNT_WIDTH, 8, width of the completed-transaction counter (>= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream presents a, b, op.
- in_ready  output  1  stage accepts this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  0=AND, 1=OR, 2=XOR, 3=XNOR (~^).
- out_valid  output  1  result y is valid.
- out_ready  input  1  downstream accepts y.
- y  output  WIDTH  registered result.
- y_zero  output  1  y == 0, registered with y.
- done_cnt  output  CNT_WIDTH  count of completed output handshakes.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs and state clear on the next rising clk edge with rst=1.
  - S1/S2 valid flags = 0, so out_valid = 0.
  - y = 0, y_zero = 1, done_cnt = 0.
  - in_ready = 1 combinationally once the S1 valid flag is 0.
  - Reset mid-transaction drops all in-flight data with no output handshake.
- Stage S1 (operand register):
  - Captures a, b, op when in_valid && in_ready.
  - s1_ready = !s2_valid || out_ready.
  - in_ready = !s1_valid || s1_ready.
- Stage S2 (result register):
  - On S1→S2 transfer, computes y = a&b / a|b / a^b / ~(a^b) per op, bitwise over WIDTH bits.
  - y_zero is registered at the same time.
- Latency: accept at edge N → out_valid=1 after edge N+1, with no backpressure.
- Throughput: 1 transaction/cycle sustained.
- Holding rule: while out_valid && !out_ready, y, y_zero and out_valid hold stable.
  - S1 fills at most once more, then in_ready drops to 0.
  - Fill sequence: accept into S1 → S1 full and S2 full, out_ready=0 → in_ready=0.
- Simultaneous events:
  - S2 drains while S1 moves: S1 data enters S2 the same edge.
  - S1 moves while a new input arrives: new input enters S1 the same edge.
  - No bubble and no loss in either case.
- done_cnt increments by 1 on each out_valid && out_ready edge.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no saturation.
- No combinational path from a, b or op to y.
  - in_ready depends combinationally on out_ready only through the ready chain.
- Unregistered inputs are don't-care when in_valid=0.
  - The stage never captures them in that case.

Optional Feature:
- Macro: BINARY_OPS_PIPE_PARITY_EN.
- Defined:
  - Adds output port y_parity (output, 1) = ^y, registered with y.
  - Reset value 0.
  - Held stable under backpressure like y.
- Undefined:
  - Port absent; no parity logic is synthesized.
  - All other behaviour is identical.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, y=0, y_zero=1, done_cnt=0. After release, in_ready=1.
2. All ops: a=8'hC3, b=8'hA5, op=0..3 back-to-back, out_ready=1 → y=8'h81, 8'hE7, 8'h66, 8'h99 on consecutive cycles. First result appears one cycle after accept. done_cnt=4.
3. Backpressure: out_ready=0, send 3 transactions (op=2, a=8'hFF, b=8'h0F/8'hF0/8'hFF):
   - Two accepted, then in_ready=0; y holds 8'hF0.
   - Raise out_ready → 8'hF0, 8'h0F, 8'h00 (y_zero=1) in order, none lost.
4. Simultaneous drain/fill: pipeline full, out_ready=1, in_valid=1 continuously → one output and one acceptance every cycle, in_ready stays 1.
5. Reset mid-stream: rst=1 with S1 and S2 full → next cycle out_valid=0, done_cnt=0. No stale result appears after release.
6. Wrap, plus parity when enabled:
   - CNT_WIDTH=2, 5 handshakes → done_cnt sequence 1,2,3,0,1.
   - With BINARY_OPS_PIPE_PARITY_EN: a=8'h07, b=8'h00, op=1 → y=8'h07, y_parity=1.
